// File: rtl/lag_stats_bcd.sv
// Lag statistics collector: tracks cur/min/max/block-average of binary lag samples and
// publishes all four as 5-digit BCD through a sequential double-dabble engine.
module lag_stats_bcd #(
    parameter int AVG_LOG2 = 4,
    parameter int LAG_W    = 17
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             lag_valid,
    input  logic [LAG_W-1:0] lag_value,
    input  logic             clear_stats,
    output logic [79:0]      bcdcount,
    output logic             bcd_update,
    output logic             busy
);

    localparam int SUM_W = LAG_W + AVG_LOG2;
    localparam int CNT_W = $clog2(LAG_W);
    localparam int DAB_W = 20 + LAG_W;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(LAG_W - 1);
    localparam logic [LAG_W-1:0] CLAMP_V  = LAG_W'(99998);
    localparam logic [LAG_W-1:0] SENT_V   = LAG_W'(99999);
    localparam logic [79:0]      RESET_BCD = {20'h99999, 20'h00000, 20'h99999, 20'h99999};

    typedef enum logic [1:0] {IDLE, LATCH, CONV, PUBLISH} state_t;

    state_t state_q;

    // statistics registers
    logic [LAG_W-1:0]    cur_q, cur_d, min_q, min_d, max_q, max_d, avg_q, avg_d;
    logic                cur_valid_q, cur_valid_d, min_valid_q, min_valid_d;
    logic                avg_valid_q, avg_valid_d, pending_q, pending_d;
    logic [SUM_W-1:0]    sum_q, sum_d, sum_plus;
    logic [AVG_LOG2-1:0] win_cnt_q, win_cnt_d;
    logic [LAG_W-1:0]    sample_v;

    // conversion engine registers
    logic [LAG_W-1:0] snap_q [4];
    logic [19:0]      res_q  [4];
    logic [19:0]      dab_bcd_q;
    logic [LAG_W-1:0] dab_bin_q;
    logic [19:0]      bcd_adj;
    logic [DAB_W-1:0] dab_shift;
    logic [1:0]       idx_q;
    logic [CNT_W-1:0] bit_cnt_q;

    always_comb begin
        sample_v    = (lag_value > CLAMP_V) ? CLAMP_V : lag_value;
        cur_d       = cur_q;
        cur_valid_d = cur_valid_q;
        min_d       = min_q;
        min_valid_d = min_valid_q;
        max_d       = max_q;
        avg_d       = avg_q;
        avg_valid_d = avg_valid_q;
        sum_d       = sum_q;
        win_cnt_d   = win_cnt_q;
        sum_plus    = '0;
        // a clear coinciding with a sample makes that sample the first of the new session
        if (clear_stats) begin
            min_valid_d = 1'b0;
            max_d       = '0;
            avg_valid_d = 1'b0;
            sum_d       = '0;
            win_cnt_d   = '0;
        end
        if (lag_valid) begin
            cur_d       = sample_v;
            cur_valid_d = 1'b1;
            if (!min_valid_d || sample_v < min_d) begin
                min_d       = sample_v;
                min_valid_d = 1'b1;
            end
            if (sample_v > max_d) begin
                max_d = sample_v;
            end
            sum_plus = sum_d + SUM_W'(sample_v);
            if (win_cnt_d == '1) begin
                avg_d       = LAG_W'(sum_plus >> AVG_LOG2);
                avg_valid_d = 1'b1;
                sum_d       = '0;
                win_cnt_d   = '0;
            end else begin
                sum_d     = sum_plus;
                win_cnt_d = win_cnt_d + AVG_LOG2'(1);
            end
        end
        pending_d = lag_valid | clear_stats | (pending_q & (state_q != LATCH));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_q       <= '0;
            cur_valid_q <= 1'b0;
            min_q       <= '0;
            min_valid_q <= 1'b0;
            max_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            sum_q       <= '0;
            win_cnt_q   <= '0;
            pending_q   <= 1'b0;
        end else begin
            cur_q       <= cur_d;
            cur_valid_q <= cur_valid_d;
            min_q       <= min_d;
            min_valid_q <= min_valid_d;
            max_q       <= max_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            sum_q       <= sum_d;
            win_cnt_q   <= win_cnt_d;
            pending_q   <= pending_d;
        end
    end

    // add-3 on every nibble >= 5, then one left shift of {bcd, bin}
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (dab_bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        dab_bcd_q[gi*4 +: 4] + 4'd3 : dab_bcd_q[gi*4 +: 4];
        end
    endgenerate

    assign dab_shift = {bcd_adj, dab_bin_q} << 1;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            bcdcount   <= RESET_BCD;
            bcd_update <= 1'b0;
            dab_bcd_q  <= '0;
            dab_bin_q  <= '0;
            idx_q      <= '0;
            bit_cnt_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                snap_q[i] <= '0;
                res_q[i]  <= '0;
            end
        end else begin
            bcd_update <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pending_q) state_q <= LATCH;
                end
                LATCH: begin
                    // invalid values convert the binary sentinel, which keeps the cycle count fixed
                    snap_q[0] <= cur_valid_q ? cur_q : SENT_V;
                    snap_q[1] <= min_valid_q ? min_q : SENT_V;
                    snap_q[2] <= max_q;
                    snap_q[3] <= avg_valid_q ? avg_q : SENT_V;
                    dab_bcd_q <= '0;
                    dab_bin_q <= cur_valid_q ? cur_q : SENT_V;
                    idx_q     <= '0;
                    bit_cnt_q <= '0;
                    state_q   <= CONV;
                end
                CONV: begin
                    dab_bcd_q <= dab_shift[LAG_W +: 20];
                    dab_bin_q <= dab_shift[LAG_W-1:0];
                    if (bit_cnt_q == LAST_BIT) begin
                        res_q[idx_q] <= dab_shift[LAG_W +: 20];
                        bit_cnt_q    <= '0;
                        if (idx_q == 2'd3) begin
                            state_q <= PUBLISH;
                        end else begin
                            idx_q     <= idx_q + 2'd1;
                            dab_bcd_q <= '0;
                            dab_bin_q <= snap_q[idx_q + 2'd1];
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                PUBLISH: begin
                    bcdcount   <= {res_q[3], res_q[2], res_q[1], res_q[0]};
                    bcd_update <= 1'b1;
                    state_q    <= pending_q ? LATCH : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lag_stats_bcd.sv
// Randomized self-checking bench for lag_stats_bcd with a queue-based statistics and timing model.
module tb_lag_stats_bcd;

    localparam int AVG_LOG2 = 4;
    localparam int LAG_W    = 17;
    localparam int WIN      = 1 << AVG_LOG2;
    localparam int MAXC     = 40000;
    localparam logic [79:0] RST_VAL = 80'h99999_00000_99999_99999;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             lag_valid = 1'b0;
    logic             clear_stats = 1'b0;
    logic [LAG_W-1:0] lag_value = '0;
    logic [79:0]      bcdcount;
    logic             bcd_update;
    logic             busy;

    lag_stats_bcd #(.AVG_LOG2(AVG_LOG2), .LAG_W(LAG_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .lag_valid   (lag_valid),
        .lag_value   (lag_value),
        .clear_stats (clear_stats),
        .bcdcount    (bcdcount),
        .bcd_update  (bcd_update),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          pulses = 0;
    bit          armed = 1'b0;
    int          cur_m = -1;
    int          sess[$];
    int          lat_q[$];
    int          pub_q[$];
    int          last_lat = -1000;
    logic [79:0] model_now = RST_VAL;
    logic [79:0] disp_exp = RST_VAL;
    logic [79:0] model_bcd [MAXC];

    task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < 5; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // statistics straight from the list of samples in the current session
    function automatic logic [79:0] compose();
        int     mn, mx, av, nb;
        longint s;
        mn = 99999;
        mx = 0;
        av = 99999;
        foreach (sess[i]) begin
            if (sess[i] < mn) mn = sess[i];
            if (sess[i] > mx) mx = sess[i];
        end
        nb = sess.size() / WIN;
        if (nb > 0) begin
            s = 0;
            for (int i = WIN*(nb-1); i < WIN*nb; i++) s += sess[i];
            av = int'(s / WIN);
        end
        return {to_bcd(av), to_bcd(mx), to_bcd(mn), to_bcd(cur_m < 0 ? 99999 : cur_m)};
    endfunction

    // model update at each edge; a conversion snapshot is taken 2 edges after the first
    // unserved event, but no earlier than 70 edges after the previous snapshot
    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            armed = 1'b1;
            cur_m = -1;
            sess.delete();
            lat_q.delete();
            pub_q.delete();
            last_lat = -1000;
            model_now = RST_VAL;
            disp_exp = RST_VAL;
        end else if (lag_valid || clear_stats) begin
            if (clear_stats) sess.delete();
            if (lag_valid) begin
                cur_m = (lag_value > 99998) ? 99998 : int'(lag_value);
                sess.push_back(cur_m);
            end
            model_now = compose();
            if (cyc >= last_lat) begin
                last_lat = (last_lat + 70 > cyc + 2) ? last_lat + 70 : cyc + 2;
                lat_q.push_back(last_lat);
                pub_q.push_back(last_lat + 69);
            end
        end
        if (cyc < MAXC) model_bcd[cyc] = model_now;
    end

    always @(negedge clock) begin
        bit exp_busy, exp_pulse;
        if (armed) begin
            while (lat_q.size() > 0 && cyc > lat_q[0] + 68) void'(lat_q.pop_front());
            exp_busy  = (lat_q.size() > 0) && (cyc >= lat_q[0] - 1);
            exp_pulse = 1'b0;
            if (pub_q.size() > 0 && pub_q[0] == cyc) begin
                exp_pulse = 1'b1;
                disp_exp  = model_bcd[cyc - 70];
                void'(pub_q.pop_front());
            end
            if (bcd_update === 1'b1) pulses++;
            check_val("busy", 80'(busy), 80'(exp_busy));
            check_val("bcd_update", 80'(bcd_update), 80'(exp_pulse));
            check_val("bcdcount", bcdcount, disp_exp);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input logic [LAG_W-1:0] v, input bit clr);
        lag_valid   = 1'b1;
        lag_value   = v;
        clear_stats = clr;
        tick(1);
        lag_valid   = 1'b0;
        clear_stats = 1'b0;
    endtask

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0, pos, r;
        logic [LAG_W-1:0] v;

        tick(3);
        reset = 1'b0;
        check_val("reset_bcd", bcdcount, RST_VAL);
        check_val("reset_busy", 80'(busy), 80'(0));
        check_val("reset_upd", 80'(bcd_update), 80'(0));

        // single sample: publish exactly 71 edges later
        send(17'd1234, 1'b0);
        tick(70);
        check_val("t2_before", bcdcount, RST_VAL);
        tick(1);
        check_val("t2_value", bcdcount, 80'h99999_01234_01234_01234);
        check_val("t2_pulse", 80'(bcd_update), 80'(1));
        tick(1);
        check_val("t2_pulse_end", 80'(bcd_update), 80'(0));
        tick(100);

        // new session starting with a same-cycle clear
        send(17'd500, 1'b1);
        tick(99);
        send(17'd200, 1'b0);
        tick(99);
        send(17'd900, 1'b0);
        tick(100);
        check_val("t3_stats", bcdcount, 80'h99999_00900_00200_00900);

        // block average with truncation
        pos = $urandom_range(0, WIN - 1);
        for (int i = 0; i < WIN; i++) begin
            send((i == pos) ? 17'd1015 : 17'd1000, i == 0);
            tick($urandom_range(0, 40));
        end
        tick(150);
        check_val("t4_avg", 80'(bcdcount[79:60]), 80'(20'h01000));

        // three strobes while busy collapse into two publishes
        p0 = pulses;
        v = LAG_W'($urandom_range(0, 99998));
        send(17'd4321, 1'b0);
        tick(4);
        send(17'd777, 1'b0);
        tick(4);
        send(v, 1'b0);
        tick(200);
        check_val("t5_pulses", 80'(pulses - p0), 80'(2));
        check_val("t5_last", 80'(bcdcount[19:0]), 80'(to_bcd(int'(v))));

        // oversized sample, reset in the middle of its conversion
        send(17'h1FFFF, 1'b0);
        tick(30);
        reset = 1'b1;
        tick(1);
        check_val("t6_abort_bcd", bcdcount, RST_VAL);
        check_val("t6_abort_busy", 80'(busy), 80'(0));
        reset = 1'b0;
        send(17'h1FFFF, 1'b0);
        tick(71);
        check_val("t6_clamp", bcdcount, 80'h99999_99998_99998_99998);
        tick(100);

        // random traffic checked cycle by cycle against the model
        for (int i = 0; i < 300; i++) begin
            tick($urandom_range(0, 120));
            r = $urandom_range(0, 99);
            if (r < 5) begin
                clear_stats = 1'b1;
                tick(1);
                clear_stats = 1'b0;
            end else if (r == 99) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
            end else begin
                v = (r < 15) ? LAG_W'($urandom_range(0, 131071)) : LAG_W'($urandom_range(0, 99999));
                send(v, r < 8);
            end
        end
        tick(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
